uio_bus_scheduler: RTL and testbench

- Shares the 8-bit bidirectional uio pad bus between NUM_REQ on-chip requesters (counter, pattern generator, loopback sampler, ...).
- Grants bus ownership round-robin for a bounded burst, then drives uio_out/uio_oe for write bursts or samples uio_in for read bursts.
- Inserts a mandatory turnaround gap so two owners never drive the pads back-to-back.
- Sits between the requester blocks and the top-level uio_* pins.

---
 rtl/uio_bus_scheduler_pkg.sv | 8 +
 rtl/uio_bus_scheduler_if.sv | 25 ++
 rtl/uio_bus_scheduler_rr_arbiter.sv | 25 ++
 rtl/uio_bus_scheduler.sv | 100 ++++++++++
 tb/tb_uio_bus_scheduler.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uio_bus_scheduler_pkg.sv
// uio_sched_pkg: shared states and pad constants for the uio bus scheduler
package uio_sched_pkg;
   typedef enum logic [1:0] {IDLE, XFER, TURN} state_e;
   localparam logic DIR_READ = 1'b0;
   localparam logic DIR_WRITE = 1'b1;
   localparam logic [7:0] OE_DRIVE = 8'hFF;
   localparam logic [7:0] OE_HIZ = 8'h00;
endpackage

// File: rtl/uio_bus_scheduler_if.sv
// uio_bus_scheduler_if: requester handshake plus uio pad signals
interface uio_bus_scheduler_if #(parameter int NUM_REQ = 4, parameter int BURST_W = 4);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] req_dir;
   logic [NUM_REQ*BURST_W-1:0] req_len;
   logic [NUM_REQ*8-1:0] req_wdata;
   logic [NUM_REQ-1:0] gnt;
   logic beat;
   logic done;
   logic abort;
   logic [7:0] rdata;
   logic rdata_vld;
   logic busy;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   modport slave (
      input req, req_dir, req_len, req_wdata, uio_in,
      output gnt, beat, done, abort, rdata, rdata_vld, busy, uio_out, uio_oe
   );
   modport master (
      output req, req_dir, req_len, req_wdata, uio_in,
      input gnt, beat, done, abort, rdata, rdata_vld, busy, uio_out, uio_oe
   );
endinterface

// File: rtl/uio_bus_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick of the first request at or after ptr_i
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int PW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PW-1:0]      win_o,
   output logic               any_o
);
   always_comb begin
      win_o = '0;
      any_o = 1'b0;
      gnt_o = '0;
      // scan farthest-first so the nearest set bit after ptr_i is written last
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[PW'((int'(ptr_i) + i) % NUM_REQ)]) begin
            win_o = PW'((int'(ptr_i) + i) % NUM_REQ);
            any_o = 1'b1;
         end
      end
      if (any_o) gnt_o[win_o] = 1'b1;
   end
endmodule

// File: rtl/uio_bus_scheduler.sv
// uio_bus_scheduler: round-robin burst ownership of the uio pads with a turnaround gap
module uio_bus_scheduler
   import uio_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BURST_W = 4,
   parameter int TURNAROUND = 1
) (
   input logic clk,
   input logic rst,
   uio_bus_scheduler_if.slave bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam state_e END_ST = (TURNAROUND == 0) ? IDLE : TURN;
   state_e state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, arb_gnt;
   logic [PW-1:0] own_q, own_d, ptr_q, ptr_d, arb_win;
   logic [BURST_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [1:0] tcnt_q, tcnt_d;
   logic [7:0] rdata_q, rdata_d;
   logic dir_q, dir_d, rvld_q, rvld_d;
   logic arb_any, own_req, beat, wr, last;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i(bus.req),
      .ptr_i(ptr_q),
      .gnt_o(arb_gnt),
      .win_o(arb_win),
      .any_o(arb_any)
   );
   assign own_req = bus.req[own_q];
   assign beat = (state_q == XFER) && own_req;
   assign wr = beat && (dir_q == DIR_WRITE);
   assign last = cnt_q == len_q;
   assign bus.gnt = gnt_q;
   assign bus.beat = beat;
   assign bus.done = beat && last;
   assign bus.abort = (state_q == XFER) && !own_req;
   assign bus.busy = state_q != IDLE;
   assign bus.rdata = rdata_q;
   assign bus.rdata_vld = rvld_q;
   // pad drive is derived from the registered state so reset tri-states it immediately
   assign bus.uio_oe = wr ? OE_DRIVE : OE_HIZ;
   assign bus.uio_out = wr ? bus.req_wdata[own_q*8 +: 8] : 8'h00;
   always_comb begin
      state_d = state_q;
      gnt_d = gnt_q;
      own_d = own_q;
      ptr_d = ptr_q;
      dir_d = dir_q;
      len_d = len_q;
      cnt_d = cnt_q;
      tcnt_d = tcnt_q;
      rvld_d = beat && (dir_q == DIR_READ);
      rdata_d = rvld_d ? bus.uio_in : rdata_q;
      case (state_q)
         IDLE: if (arb_any) begin
            state_d = XFER;
            gnt_d = arb_gnt;
            own_d = arb_win;
            ptr_d = (arb_win == PW'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
            dir_d = bus.req_dir[arb_win];
            len_d = bus.req_len[arb_win*BURST_W +: BURST_W];
            cnt_d = '0;
         end
         XFER: if (!own_req || last) begin
            state_d = END_ST;
            gnt_d = '0;
            tcnt_d = '0;
         end else cnt_d = cnt_q + 1'b1;
         TURN: if (tcnt_q == 2'(TURNAROUND - 1)) state_d = IDLE;
               else tcnt_d = tcnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q <= '0;
         own_q <= '0;
         ptr_q <= '0;
         dir_q <= DIR_READ;
         len_q <= '0;
         cnt_q <= '0;
         tcnt_q <= '0;
         rdata_q <= '0;
         rvld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         own_q <= own_d;
         ptr_q <= ptr_d;
         dir_q <= dir_d;
         len_q <= len_d;
         cnt_q <= cnt_d;
         tcnt_q <= tcnt_d;
         rdata_q <= rdata_d;
         rvld_q <= rvld_d;
      end
   end
endmodule

// File: tb/tb_uio_bus_scheduler.sv
// tb_uio_bus_scheduler: vector table, corner sequences and a timeline reference model
module tb_uio_bus_scheduler;
   localparam int N = 4;
   localparam int BW = 4;
   localparam int TA = 1;
   typedef struct {
      logic [3:0] req, dir;
      logic [15:0] len;
      logic [31:0] wd;
      logic [7:0] ui;
      logic [3:0] gnt;
      logic beat, done, abort, busy, rvld;
      logic [7:0] oe, out, rd;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   uio_bus_scheduler_if #(.NUM_REQ(N), .BURST_W(BW)) bus ();
   uio_bus_scheduler_if #(.NUM_REQ(N), .BURST_W(BW)) bus0 ();
   uio_bus_scheduler #(.NUM_REQ(N), .BURST_W(BW), .TURNAROUND(TA)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   uio_bus_scheduler #(.NUM_REQ(N), .BURST_W(BW), .TURNAROUND(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   int n_chk = 0;
   int n_fail = 0;
   int m_own, m_dir, m_len, m_cnt, m_ptr, m_free;
   logic m_rvld;
   logic [7:0] m_rd;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [32:0] obs();
      return {bus.gnt, bus.beat, bus.done, bus.abort, bus.busy, bus.rdata_vld, bus.uio_oe, bus.uio_out, bus.rdata};
   endfunction
   task automatic idle_inputs();
      bus.req = '0; bus.req_dir = '0; bus.req_len = '0; bus.req_wdata = '0; bus.uio_in = '0;
      bus0.req = '0; bus0.req_dir = '0; bus0.req_len = '0; bus0.req_wdata = '0; bus0.uio_in = '0;
   endtask
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask
   // outputs of cycle t from the burst timeline, then advance the timeline past edge t
   task automatic model_step(input int t, output logic [32:0] e);
      logic [3:0] g;
      logic b, d, a, bz;
      logic [7:0] oe, out;
      int w;
      g = '0; b = 1'b0; d = 1'b0; a = 1'b0;
      if (m_own >= 0) begin
         g[m_own] = 1'b1;
         b = bus.req[m_own];
         a = !b;
         d = b && (m_cnt == m_len);
      end
      bz = (m_own >= 0) || (t < m_free);
      oe = (b && m_dir == 1) ? 8'hFF : 8'h00;
      out = (b && m_dir == 1) ? bus.req_wdata[m_own*8 +: 8] : 8'h00;
      e = {g, b, d, a, bz, m_rvld, oe, out, m_rd};
      m_rvld = b && (m_dir == 0);
      if (m_rvld) m_rd = bus.uio_in;
      if (m_own >= 0) begin
         if (a || d) begin
            m_own = -1;
            m_free = t + 1 + TA;
         end else m_cnt++;
      end else if (t >= m_free) begin
         w = -1;
         for (int o = 0; o < N; o++)
            if (w < 0 && bus.req[(m_ptr + o) % N]) w = (m_ptr + o) % N;
         if (w >= 0) begin
            m_own = w;
            m_dir = int'(bus.req_dir[w]);
            m_len = int'(bus.req_len[w*BW +: BW]);
            m_cnt = 0;
            m_ptr = (w + 1) % N;
         end
      end
   endtask
   initial begin
      vec_t tv[11];
      logic [3:0] g[15];
      logic bz[15];
      logic found, pulses;
      logic [32:0] e;
      int beats, aborts, dones;
      tv[0]  = '{4'b0010, 4'b0010, 16'h0020, 32'h0000A500, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tv[1]  = '{4'b0010, 4'b0010, 16'h0020, 32'h0000A500, 8'h00, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5, 8'h00};
      tv[2]  = '{4'b0010, 4'b0010, 16'h0020, 32'h0000A500, 8'h00, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5, 8'h00};
      tv[3]  = '{4'b0010, 4'b0010, 16'h0020, 32'h0000A500, 8'h00, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5, 8'h00};
      tv[4]  = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
      tv[5]  = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tv[6]  = '{4'b0001, 4'b0000, 16'h0001, 32'h00000000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tv[7]  = '{4'b0001, 4'b0000, 16'h0001, 32'h00000000, 8'h3C, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
      tv[8]  = '{4'b0001, 4'b0000, 16'h0001, 32'h00000000, 8'hC3, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h3C};
      tv[9]  = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'hC3};
      tv[10] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         bus.req = tv[i].req; bus.req_dir = tv[i].dir; bus.req_len = tv[i].len;
         bus.req_wdata = tv[i].wd; bus.uio_in = tv[i].ui;
         @(negedge clk);
         chk($sformatf("vec%0d", i), obs(), {tv[i].gnt, tv[i].beat, tv[i].done, tv[i].abort, tv[i].busy,
                                             tv[i].rvld, tv[i].oe, tv[i].out, tv[i].rd});
         next_cyc();
      end
      do_reset();
      bus.req = 4'b1000; bus.req_dir = 4'b1000; bus.req_len = 16'h7000; bus.req_wdata = 32'h5A000000;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(negedge clk);
         if (bus.uio_oe == 8'hFF) found = 1'b1;
         else next_cyc();
      end
      chk("rst_reach_write", found, 1);
      #1 rst = 1'b1;
      bus.req = '0;
      #1 chk("rst_async_hiz", {bus.uio_oe, bus.gnt, bus.busy}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      pulses = 1'b0;
      repeat (5) begin
         @(negedge clk);
         pulses |= bus.done | bus.abort;
         next_cyc();
      end
      chk("rst_no_pulse", pulses, 0);
      do_reset();
      bus.req = 4'hF; bus.req_dir = 4'hF; bus.req_len = '0; bus.req_wdata = 32'h44332211;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         g[c] = bus.gnt;
         bz[c] = bus.busy;
         next_cyc();
      end
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("rr_gnt%0d", j), g[1+3*j], 4'b0001 << (j % 4));
         chk($sformatf("rr_turn%0d", j), {g[2+3*j], bz[2+3*j]}, {4'b0000, 1'b1});
      end
      do_reset();
      bus.req = 4'b0100; bus.req_dir = 4'b0100; bus.req_len = 16'h0700; bus.req_wdata = 32'h00C30000;
      beats = 0; aborts = 0; dones = 0;
      for (int c = 0; c < 7; c++) begin
         if (c == 4) bus.req = '0;
         @(negedge clk);
         beats += int'(bus.beat); aborts += int'(bus.abort); dones += int'(bus.done);
         if (c == 4) chk("abort_cycle", {bus.abort, bus.beat, bus.uio_oe, bus.gnt}, {1'b1, 1'b0, 8'h00, 4'b0100});
         if (c == 5) chk("abort_turn", {bus.gnt, bus.busy}, {4'b0000, 1'b1});
         next_cyc();
      end
      chk("abort_beats", beats, 3);
      chk("abort_pulses", aborts, 1);
      chk("abort_no_done", dones, 0);
      do_reset();
      bus0.req = 4'b0010; bus0.req_dir = 4'b0010; bus0.req_len = 16'h00F0; bus0.req_wdata = 32'h00007E00;
      beats = 0; dones = 0;
      for (int c = 0; c < 21; c++) begin
         if (c == 3) bus0.req_len = 16'h0020;
         @(negedge clk);
         if (c >= 1 && c <= 16) beats += int'(bus0.beat);
         if (c < 16) dones += int'(bus0.done);
         if (c == 16) chk("max_done16", {bus0.done, bus0.uio_oe, bus0.uio_out}, {1'b1, 8'hFF, 8'h7E});
         if (c == 17) chk("ta0_idle", {bus0.beat, bus0.busy, bus0.gnt}, 0);
         if (c == 18) chk("ta0_rebeat", bus0.beat, 1);
         if (c == 20) chk("ta0_new_len", bus0.done, 1);
         next_cyc();
      end
      chk("max_beats", beats, 16);
      chk("max_no_early_done", dones, 0);
      do_reset();
      m_own = -1; m_ptr = 0; m_free = 0; m_rvld = 1'b0; m_rd = 8'h00;
      m_dir = 0; m_len = 0; m_cnt = 0;
      for (int t = 0; t < 2000; t++) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
               if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
            bus.req_len[i*BW +: BW] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
         end
         bus.req_dir = 4'($urandom);
         bus.req_wdata = $urandom;
         bus.uio_in = 8'($urandom);
         @(negedge clk);
         model_step(t, e);
         chk($sformatf("rand_t%0d", t), obs(), e);
         next_cyc();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
